scan_chain_ctrl: RTL

//  Sequencer for one FF_scan chain: drives the shared scan-enable (SE) and serial scan-in (SD) lines.

---
 rtl/scan_chain_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/scan_chain_ctrl.sv
// ============================================================================
//  Module   : scan_chain_ctrl
//  Purpose  : Shift-in / capture / shift-out sequencer for a single scan chain,
//             with per-bit comparison of the captured response.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 scan_out,
    output logic                 se,
    output logic                 sd,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [CHAIN_LEN-1:0] fail_vec
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHIFT_IN  = 3'd1;
    localparam logic [2:0] S_CAPTURE   = 3'd2;
    localparam logic [2:0] S_SHIFT_OUT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CHAIN_LEN - 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] sr_q, sr_d;
    logic                 se_q, se_d;
    logic                 sd_q, sd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [CHAIN_LEN-1:0] captured_q, captured_d;
    logic [CHAIN_LEN-1:0] fail_vec_q, fail_vec_d;

    logic                 w_last;
    logic [CHAIN_LEN-1:0] w_pat_sh;
    logic [CHAIN_LEN-1:0] w_sr_next;

    assign w_last    = (cnt_q == C_LAST);
    // Bit CHAIN_LEN-2 of the shifted copy is the next MSB-first stimulus bit.
    assign w_pat_sh  = pat_q << cnt_q;
    assign w_sr_next = {sr_q[CHAIN_LEN-2:0], scan_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            exp_q      <= '0;
            sr_q       <= '0;
            se_q       <= 1'b0;
            sd_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= '0;
            fail_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            exp_q      <= exp_d;
            sr_q       <= sr_d;
            se_q       <= se_d;
            sd_q       <= sd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            captured_q <= captured_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start && !abort) state_d = S_SHIFT_IN;
            S_SHIFT_IN:  if (abort) state_d = S_IDLE;
                         else if (w_last) state_d = S_CAPTURE;
            S_CAPTURE:   state_d = abort ? S_IDLE : S_SHIFT_OUT;
            S_SHIFT_OUT: if (abort) state_d = S_IDLE;
                         else if (w_last) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        exp_d      = exp_q;
        sr_d       = sr_q;
        se_d       = se_q;
        sd_d       = sd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        captured_d = captured_q;
        fail_vec_d = fail_vec_q;
        if (state_q != S_IDLE && abort) begin
            se_d   = 1'b0;
            sd_d   = 1'b0;
            busy_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    se_d = 1'b0;
                    sd_d = 1'b0;
                    if (start && !abort) begin
                        pat_d  = pattern;
                        exp_d  = expected;
                        busy_d = 1'b1;
                        se_d   = 1'b1;
                        sd_d   = pattern[CHAIN_LEN-1];
                        cnt_d  = '0;
                    end
                end
                S_SHIFT_IN: begin
                    if (w_last) begin
                        se_d = 1'b0;
                        sd_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        sd_d  = w_pat_sh[CHAIN_LEN-2];
                    end
                end
                S_CAPTURE: begin
                    se_d  = 1'b1;
                    sd_d  = 1'b0;
                    cnt_d = '0;
                end
                S_SHIFT_OUT: begin
                    sr_d = w_sr_next;
                    if (w_last) begin
                        se_d       = 1'b0;
                        captured_d = w_sr_next;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    pass_d     = (captured_q == exp_q);
                    fail_vec_d = captured_q ^ exp_q;
                end
                default: begin
                    se_d   = 1'b0;
                    sd_d   = 1'b0;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    assign se       = se_q;
    assign sd       = sd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign captured = captured_q;
    assign fail_vec = fail_vec_q;

endmodule

`default_nettype wire
